// File: rtl/nibble_protocol_responder.sv
// Byte-level responder between a UART pair and a compute core.
// Nibbles shift through a WIDTH-bit operand register; the core result is read back the same way.
module nibble_protocol_responder #(
    parameter int WIDTH = 368
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_new_byte,
    input  logic [7:0]       rx_byte,
    input  logic             tx_ready,
    output logic             tx_new_byte,
    output logic [7:0]       tx_byte,
    output logic             core_start,
    output logic [WIDTH-1:0] core_x,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_y,
    output logic             busy
);

    localparam logic [3:0] LOAD       = 4'h1;
    localparam logic [3:0] ACKLOAD    = 4'h2;
    localparam logic [3:0] COMPUTE    = 4'h3;
    localparam logic [3:0] ACKCOMPUTE = 4'h4;
    localparam logic [3:0] NACK       = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        START,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [7:0]       resp_q, resp_d;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        resp_d  = resp_q;
        unique case (state_q)
            IDLE: begin
                if (rx_new_byte) begin
                    if (rx_byte[3:0] == LOAD) begin
                        // The outgoing LSB nibble is captured before the new nibble shifts in at the top.
                        resp_d  = {sreg_q[3:0], ACKLOAD};
                        sreg_d  = {rx_byte[7:4], sreg_q[WIDTH-1:4]};
                        state_d = RESP;
                    end else if (rx_byte[3:0] == COMPUTE) begin
                        state_d = START;
                    end else begin
                        resp_d  = {4'h0, NACK};
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (core_done) begin
                    sreg_d  = core_y;
                    resp_d  = {4'h0, ACKCOMPUTE};
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            resp_q  <= resp_d;
        end
    end

    // tx_new_byte follows tx_ready directly so a reply goes out the cycle after the request.
    assign tx_new_byte = (state_q == RESP) && tx_ready;
    assign tx_byte     = (state_q == RESP) ? resp_q : 8'h00;
    assign core_start  = (state_q == START);
    assign busy        = (state_q == START) || (state_q == BUSY);
    assign core_x      = sreg_q;

endmodule

// File: tb/tb_nibble_protocol_responder.sv
// Directed bench for nibble_protocol_responder: load, compute, readback, errors, backpressure, resets.
module tb_nibble_protocol_responder;

    localparam int WIDTH = 368;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             rx_new_byte;
    logic [7:0]       rx_byte;
    logic             tx_ready;
    logic             tx_new_byte;
    logic [7:0]       tx_byte;
    logic             core_start;
    logic [WIDTH-1:0] core_x;
    logic             core_done;
    logic [WIDTH-1:0] core_y;
    logic             busy;

    int vectors;
    int miscompares;
    logic [WIDTH-1:0] y_value;
    logic [WIDTH-1:0] exp_sreg;

    nibble_protocol_responder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_new_byte(rx_new_byte),
        .rx_byte    (rx_byte),
        .tx_ready   (tx_ready),
        .tx_new_byte(tx_new_byte),
        .tx_byte    (tx_byte),
        .core_start (core_start),
        .core_x     (core_x),
        .core_done  (core_done),
        .core_y     (core_y),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] make_core_y();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < NIB; k++) begin
            v[WIDTH-1-4*k -: 4] = (k == NIB - 1) ? 4'h5 : 4'((k % 15) + 1);
        end
        return v;
    endfunction

    // Sends one byte and waits (bounded) for the reply strobe; returns the byte and latency.
    task automatic send_and_get(input logic [7:0] b, output logic [7:0] rb, output bit got,
                                output int lat);
        @(negedge clk);
        rx_new_byte = 1'b1;
        rx_byte     = b;
        @(negedge clk);
        rx_new_byte = 1'b0;
        rx_byte     = 8'h00;
        got = 1'b0;
        rb  = 8'h00;
        lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (tx_new_byte) begin
                got = 1'b1;
                rb  = tx_byte;
                lat = i + 1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy got %b exp 0", busy);
        end
        vectors++;
        if (tx_new_byte !== 1'b0 || core_start !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes got tx=%b start=%b exp 0 0", tx_new_byte, core_start);
        end
        vectors++;
        if (tx_byte !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_tx_byte got %h exp 00", tx_byte);
        end
        vectors++;
        if (core_x !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_core_x got %h exp 0", core_x);
        end
    endtask

    task automatic test_load();
        logic [7:0] rb;
        bit got;
        int lat;
        int bad;
        bad = 0;
        for (int i = 0; i < NIB; i++) begin
            send_and_get({(i == 0) ? 4'h2 : 4'h0, 4'h1}, rb, got, lat);
            vectors++;
            if (!got || rb !== 8'h02) begin
                miscompares++;
                bad++;
                if (bad < 4) $display("[TB] FAIL load_resp[%0d] got %h (seen=%0d) exp 02", i, rb, got);
            end
            if (i == 0) begin
                vectors++;
                if (lat !== 1) begin
                    miscompares++;
                    $display("[TB] FAIL load_latency got %0d exp 1", lat);
                end
                @(negedge clk);
                #1;
                vectors++;
                if (tx_new_byte !== 1'b0 || tx_byte !== 8'h00) begin
                    miscompares++;
                    $display("[TB] FAIL load_one_shot got tx=%b byte=%h exp 0 00", tx_new_byte, tx_byte);
                end
            end
        end
        exp_sreg = WIDTH'(2);
        @(negedge clk);
        #1;
        vectors++;
        if (core_x !== exp_sreg) begin
            miscompares++;
            $display("[TB] FAIL load_core_x got %h exp %h", core_x, exp_sreg);
        end
    endtask

    task automatic test_compute();
        int starts;
        int txs;
        int overlap;
        @(negedge clk);
        rx_new_byte = 1'b1;
        rx_byte     = 8'hA3;
        @(negedge clk);
        rx_new_byte = 1'b0;
        rx_byte     = 8'h00;
        #1;
        vectors++;
        if (core_start !== 1'b1 || busy !== 1'b1 || core_x !== exp_sreg) begin
            miscompares++;
            $display("[TB] FAIL compute_start got start=%b busy=%b x=%h exp 1 1 %h",
                     core_start, busy, core_x, exp_sreg);
        end
        starts = 0;
        txs = 0;
        overlap = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (i == 100) begin
                rx_new_byte = 1'b1;
                rx_byte     = 8'hF1;
            end else begin
                rx_new_byte = 1'b0;
                rx_byte     = 8'h00;
            end
            #1;
            if (core_start) starts++;
            if (tx_new_byte) txs++;
            if (core_start && tx_new_byte) overlap++;
            if (i == 103) begin
                vectors++;
                if (core_x !== exp_sreg || busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL busy_drop got x=%h busy=%b exp %h 1", core_x, busy, exp_sreg);
                end
            end
        end
        vectors++;
        if (starts !== 0 || txs !== 0 || overlap !== 0) begin
            miscompares++;
            $display("[TB] FAIL compute_wait got starts=%0d tx=%0d overlap=%0d exp 0 0 0",
                     starts, txs, overlap);
        end
        @(negedge clk);
        core_done   = 1'b1;
        core_y      = y_value;
        rx_new_byte = 1'b1;
        rx_byte     = 8'h51;
        @(negedge clk);
        core_done   = 1'b0;
        core_y      = '0;
        rx_new_byte = 1'b0;
        rx_byte     = 8'h00;
        #1;
        exp_sreg = y_value;
        vectors++;
        if (tx_new_byte !== 1'b1 || tx_byte !== 8'h04 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL compute_resp got tx=%b byte=%h busy=%b exp 1 04 0",
                     tx_new_byte, tx_byte, busy);
        end
        vectors++;
        if (core_x !== exp_sreg) begin
            miscompares++;
            $display("[TB] FAIL compute_sreg got %h exp %h", core_x, exp_sreg);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (tx_new_byte !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL compute_one_shot got %b exp 0", tx_new_byte);
        end
    endtask

    task automatic test_readback();
        logic [7:0] rb;
        bit got;
        int lat;
        int bad;
        logic [WIDTH-1:0] assembled;
        assembled = '0;
        bad = 0;
        for (int i = 0; i < NIB; i++) begin
            send_and_get(8'h01, rb, got, lat);
            assembled[4*i +: 4] = rb[7:4];
            vectors++;
            if (!got || rb[3:0] !== 4'h2) begin
                miscompares++;
                bad++;
                if (bad < 4) $display("[TB] FAIL readback_ack[%0d] got %h (seen=%0d) exp x2", i, rb, got);
            end
        end
        vectors++;
        if (assembled !== y_value) begin
            miscompares++;
            $display("[TB] FAIL readback_value got %h exp %h", assembled, y_value);
        end
        exp_sreg = '0;
        @(negedge clk);
        #1;
        vectors++;
        if (core_x !== exp_sreg) begin
            miscompares++;
            $display("[TB] FAIL readback_sreg got %h exp 0", core_x);
        end
    endtask

    task automatic test_errors();
        logic [7:0] rb;
        bit got;
        int lat;
        logic [7:0] bad_ops [3];
        int txs;
        bad_ops = '{8'h97, 8'h00, 8'h5F};
        send_and_get(8'hA1, rb, got, lat);
        exp_sreg = {4'hA, exp_sreg[WIDTH-1:4]};
        vectors++;
        if (!got || rb !== 8'h02) begin
            miscompares++;
            $display("[TB] FAIL err_preload got %h (seen=%0d) exp 02", rb, got);
        end
        for (int i = 0; i < 3; i++) begin
            send_and_get(bad_ops[i], rb, got, lat);
            vectors++;
            if (!got || rb !== 8'h0F) begin
                miscompares++;
                $display("[TB] FAIL nack[%h] got %h (seen=%0d) exp 0F", bad_ops[i], rb, got);
            end
            vectors++;
            if (core_x !== exp_sreg) begin
                miscompares++;
                $display("[TB] FAIL nack_sreg[%h] got %h exp %h", bad_ops[i], core_x, exp_sreg);
            end
        end
        @(negedge clk);
        core_done = 1'b1;
        core_y    = {WIDTH{1'b1}};
        @(negedge clk);
        core_done = 1'b0;
        core_y    = '0;
        txs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (tx_new_byte) txs++;
        end
        vectors++;
        if (txs !== 0 || core_x !== exp_sreg) begin
            miscompares++;
            $display("[TB] FAIL idle_done got tx=%0d x=%h exp 0 %h", txs, core_x, exp_sreg);
        end
    endtask

    task automatic test_backpressure();
        int pulses;
        bit held_ok;
        @(negedge clk);
        tx_ready    = 1'b0;
        rx_new_byte = 1'b1;
        rx_byte     = 8'h51;
        pulses  = 0;
        held_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rx_new_byte = 1'b0;
            rx_byte     = 8'h00;
            #1;
            if (tx_new_byte) pulses++;
            if (tx_byte !== 8'h02) held_ok = 1'b0;
        end
        vectors++;
        if (pulses !== 0 || !held_ok) begin
            miscompares++;
            $display("[TB] FAIL bp_hold got pulses=%0d held=%0d exp 0 1", pulses, held_ok);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        vectors++;
        if (tx_new_byte !== 1'b1 || tx_byte !== 8'h02) begin
            miscompares++;
            $display("[TB] FAIL bp_release got tx=%b byte=%h exp 1 02", tx_new_byte, tx_byte);
        end
        @(negedge clk);
        #1;
        exp_sreg = {4'h5, exp_sreg[WIDTH-1:4]};
        vectors++;
        if (tx_new_byte !== 1'b0 || tx_byte !== 8'h00 || core_x !== exp_sreg) begin
            miscompares++;
            $display("[TB] FAIL bp_after got tx=%b byte=%h x=%h exp 0 00 %h",
                     tx_new_byte, tx_byte, core_x, exp_sreg);
        end
    endtask

    task automatic test_reset_busy();
        int txs;
        @(negedge clk);
        rx_new_byte = 1'b1;
        rx_byte     = 8'h03;
        @(negedge clk);
        rx_new_byte = 1'b0;
        rx_byte     = 8'h00;
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rb_busy got %b exp 1", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        core_done = 1'b1;
        core_y    = y_value;
        @(negedge clk);
        core_done = 1'b0;
        core_y    = '0;
        txs = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (tx_new_byte) txs++;
            @(negedge clk);
        end
        #1;
        vectors++;
        if (txs !== 0 || busy !== 1'b0 || core_start !== 1'b0 || tx_byte !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL rb_outputs got tx=%0d busy=%b start=%b byte=%h exp 0 0 0 00",
                     txs, busy, core_start, tx_byte);
        end
        vectors++;
        if (core_x !== '0) begin
            miscompares++;
            $display("[TB] FAIL rb_sreg got %h exp 0", core_x);
        end
    endtask

    task automatic test_reset_resp();
        int txs;
        @(negedge clk);
        tx_ready    = 1'b0;
        rx_new_byte = 1'b1;
        rx_byte     = 8'h71;
        @(negedge clk);
        rx_new_byte = 1'b0;
        rx_byte     = 8'h00;
        #1;
        vectors++;
        if (tx_byte !== 8'h02) begin
            miscompares++;
            $display("[TB] FAIL rr_pending got %h exp 02", tx_byte);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        tx_ready = 1'b1;
        txs = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (tx_new_byte) txs++;
            @(negedge clk);
        end
        vectors++;
        if (txs !== 0 || core_x !== '0) begin
            miscompares++;
            $display("[TB] FAIL rr_discard got tx=%0d x=%h exp 0 0", txs, core_x);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rx_new_byte = 1'b0;
        rx_byte     = 8'h00;
        tx_ready    = 1'b1;
        core_done   = 1'b0;
        core_y      = '0;
        exp_sreg    = '0;
        y_value     = make_core_y();
        test_reset();
        test_load();
        test_compute();
        test_readback();
        test_errors();
        test_backpressure();
        test_reset_busy();
        test_reset_resp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
